rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
Parameterised round-robin arbiter that shares one resource between N requesters. It replaces the fixed-priority arbiter wherever starvation matters. A grant is locked to its owner while the owner's request stays high. A tenure counter forces handoff after MAX_HOLD cycles if another requester is waiting. Grants are registered, one-hot, and at most one is active at a time.

Parameters:
N, 3, number of requesters (>= 2)
MAX_HOLD, 8, maximum consecutive grant cycles while others wait (>= 2)
IDX_W, $clog2(N), width of owner index (derived, not overridden)
CNT_W, $clog2(MAX_HOLD+1), width of tenure counter (derived)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
r  in  N  request vector, bit i = requester i
g  out  N  registered one-hot grant vector, all-zero when idle
busy  out  1  registered, equals |g
owner  out  IDX_W  registered index of granted requester, 0 when idle
preempt  out  1  one-cycle pulse, aligned with the first cycle of a grant produced by tenure expiry

Behaviour:
- Reset (async assert, sync release): g=0, busy=0, owner=0, preempt=0, ptr=0, cnt=0, state IDLE. Outputs drop immediately on assert, including mid-grant.
- Pick function: first set bit of candidate mask scanning ascending, circular, starting at ptr.
- State IDLE:
  - If r != 0 at an edge, g = onehot(pick(r)) after that edge; 1-cycle request-to-grant latency.
  - cnt=1, go to GRANT.
  - Otherwise stay idle.
- State GRANT, evaluated at each edge with o = owner:
  - Voluntary release (r[o]=0): ptr=o+1 mod N. If r & ~onehot(o) != 0, hand off directly to the pick result (no idle gap), cnt=1, preempt=0. Else g=0, go to IDLE.
  - Forced release (r[o]=1, cnt==MAX_HOLD, other requests pending): same handoff as voluntary, and preempt=1 for that one cycle. The old owner gets exactly MAX_HOLD grant cycles.
  - Hold (r[o]=1, otherwise): g unchanged. cnt increments, saturating at MAX_HOLD.
  - Saturated hold: if no other request is pending, the grant holds indefinitely. A forced release fires on the first edge another request is seen.
- Counting: cnt counts cycles g has been visible. The first grant cycle counts as 1.
- Simultaneous events: the owner dropping r in the same cycle others assert is a voluntary release, preempt=0. New requests arriving mid-tenure never disturb the current grant before expiry.
- Excluded owner: the owner is never re-picked on its own handoff edge. It may win again later by rotation.
- preempt is low in every cycle except the single handoff cycle described above.
- Invariants: $onehot0(g) always. busy == |g. g[owner] == 1 whenever busy.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0,... with MAX_HOLD cycles each.

Decomposition:
- Package arb_pkg: state enum (ARB_IDLE, ARB_GRANT) and an onehot-to-index function, shared with future arbiters.
- Sub-module rr_pick: combinational, inputs req[N], ptr[IDX_W], outputs gnt_oh[N], idx[IDX_W], any. Implemented as a double-width masked priority scan.
- Top level holds the FSM, ptr, cnt and output registers.

Test Plan (all with N=3, MAX_HOLD=8):
1. Reset grant: hold reset with r=111 -> g=000, busy=0. Release reset -> first edge gives g=001, owner=0.
2. Single requester: r=010 held 20 cycles -> g=010 for all 20 cycles, preempt never asserts. Drop r -> g=000, busy=0 next cycle.
3. Full contention: r=111 held -> g = 001 x8, 010 x8, 100 x8, 001... preempt pulses exactly on each change, including wrap 100->001.
4. Voluntary handoff: owner 0 with r=011, clear r[0] after 3 grant cycles -> next cycle g=010, preempt=0. Requester 1 then gets a full 8 cycles if r=111 is applied.
5. Rotation: owner 1 releases with r=101 pending -> g=100 (ptr=2), not 001. After 100 releases -> g=001.
6. Reset mid-grant: assert reset while g=100 -> g=000 immediately, with no clock edge. Release with r=111 -> g=001.

Source files
------------

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared arbiter definitions: FSM state type and one-hot to index helper.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Index of the set bit in a one-hot (or all-zero) vector of up to 32 bits.
  // OR-ing the indices of set bits gives the index when exactly one is set.
  function automatic int unsigned oh2idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle for rr_lock_arbiter.
//   r       : request vector, bit i = requester i
//   g       : registered one-hot grant, zero when idle
//   busy    : registered, equals |g
//   owner   : index of granted requester, 0 when idle
//   preempt : one-cycle pulse on the first cycle of a tenure-expiry grant
// master = requester side, slave = arbiter side.
interface rr_lock_arbiter_if #(
  parameter int unsigned N = 3
) ();
  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]     r;
  logic [N-1:0]     g;
  logic             busy;
  logic [IDX_W-1:0] owner;
  logic             preempt;

  modport master (output r, input g, busy, owner, preempt);
  modport slave  (input r, output g, busy, owner, preempt);
endinterface

// File: rtl/rr_lock_arbiter_pick.sv
// Circular first-set-bit picker.
//   req    : candidate mask
//   ptr    : scan start position
//   gnt_oh : one-hot winner (zero if req == 0)
//   idx    : winner index
//   any    : req != 0
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] first;
  logic           found;

  // Lower half holds only requests at or above ptr; the unmasked upper half
  // supplies the wrap-around, so a linear scan of both halves is circular.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (i >= 32'(ptr));
    end
    dbl   = {req, req & hi_mask};
    first = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (dbl[i] && !found) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign gnt_oh = first[N-1:0] | first[2*N-1:N];
  assign any    = found;
  assign idx    = IDX_W'(oh2idx(32'(gnt_oh)));

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking and tenure-limited preemption.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of rr_lock_arbiter_if (r in; g, busy, owner, preempt out)
// The owner keeps its grant while requesting; after MAX_HOLD cycles it is
// forced off if another requester waits. Handoffs never insert an idle cycle.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic           clk,
  input logic           reset,
  rr_lock_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     g_q, g_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             preempt_q, preempt_d;
  logic             busy_q;

  logic [N-1:0]     pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] after_owner;
  logic             own_req;

  rr_pick #(.N(N)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign after_owner = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
  assign own_req     = bus.r[owner_q];

  // While granted, the picker sees the other requesters only, scanning from
  // owner+1, which is exactly the pointer value a release commits.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    g_d       = g_q;
    owner_d   = owner_q;
    preempt_d = 1'b0;
    pick_req  = bus.r;
    pick_ptr  = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          g_d     = pick_oh;
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        pick_req = bus.r & ~g_q;
        pick_ptr = after_owner;
        if (!own_req || (cnt_q == CNT_W'(MAX_HOLD) && pick_any)) begin
          ptr_d = after_owner;
          if (pick_any) begin
            g_d       = pick_oh;
            owner_d   = pick_idx;
            cnt_d     = CNT_W'(1);
            preempt_d = own_req;
          end else begin
            g_d     = '0;
            owner_d = '0;
            cnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      g_q       <= '0;
      owner_q   <= '0;
      preempt_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      g_q       <= g_d;
      owner_q   <= owner_d;
      preempt_q <= preempt_d;
      busy_q    <= |g_d;
    end
  end

  assign bus.g       = g_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
module tb_rr_lock_arbiter;
  localparam int NN = 3;
  localparam int MH = 8;

  typedef struct packed {
    logic [2:0] g;
    logic       busy;
    logic [1:0] owner;
    logic       preempt;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   m_owner;
  int   m_ten;
  int   m_ptr;
  exp_t expq[$];
  exp_t mon_e;

  rr_lock_arbiter_if #(.N(NN)) bus ();

  rr_lock_arbiter #(.N(NN), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // First requester in m at or after p, circularly; -1 if none.
  function automatic int pick(input int p, input logic [2:0] m);
    for (int k = 0; k < NN; k++) begin
      if (m[(p + k) % NN]) return (p + k) % NN;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ten   = 0;
    m_ptr   = 0;
  endtask

  // Applies the arbitration rules for one clock edge with requests rv and
  // queues the outputs expected after that edge.
  task automatic model_edge(input logic [2:0] rv);
    exp_t       e;
    logic [2:0] oth;
    int         old;
    e.preempt = 1'b0;
    if (m_owner < 0) begin
      if (rv != 3'b000) begin
        m_owner = pick(m_ptr, rv);
        m_ten   = 1;
      end
    end else begin
      old      = m_owner;
      oth      = rv;
      oth[old] = 1'b0;
      if (!rv[old] || (m_ten >= MH && oth != 3'b000)) begin
        m_ptr = (old + 1) % NN;
        if (oth != 3'b000) begin
          m_owner   = pick(m_ptr, oth);
          m_ten     = 1;
          e.preempt = rv[old];
        end else begin
          m_owner = -1;
          m_ten   = 0;
        end
      end else if (m_ten < MH) begin
        m_ten++;
      end
    end
    e.g     = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    e.busy  = (m_owner >= 0);
    e.owner = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    expq.push_back(e);
  endtask

  task automatic step(input logic [2:0] rv, input bit rel);
    @(negedge clk);
    if (rel) reset = 1'b0;
    bus.r = rv;
    model_edge(rv);
  endtask

  task automatic run(input logic [2:0] rv, input int n);
    repeat (n) step(rv, 1'b0);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.g !== 3'b000 || bus.busy !== 1'b0 || bus.owner !== 2'd0 || bus.preempt !== 1'b0) begin
      errors++;
      $display("FAIL %s: got g=%b busy=%b owner=%0d preempt=%b, want g=000 busy=0 owner=0 preempt=0",
               name, bus.g, bus.busy, bus.owner, bus.preempt);
    end
  endtask

  // Monitor: compares each registered output set against the queued prediction.
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      checks++;
      if (bus.g !== mon_e.g || bus.busy !== mon_e.busy ||
          bus.owner !== mon_e.owner || bus.preempt !== mon_e.preempt) begin
        errors++;
        $display("FAIL outputs t=%0t: got g=%b busy=%b owner=%0d preempt=%b, want g=%b busy=%b owner=%0d preempt=%b",
                 $time, bus.g, bus.busy, bus.owner, bus.preempt,
                 mon_e.g, mon_e.busy, mon_e.owner, mon_e.preempt);
      end
      checks++;
      if (!$onehot0(bus.g) || (bus.busy !== (|bus.g)) || (bus.busy && !bus.g[bus.owner])) begin
        errors++;
        $display("FAIL invariant t=%0t: g=%b busy=%b owner=%0d", $time, bus.g, bus.busy, bus.owner);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    reset  = 1'b1;
    bus.r  = 3'b000;
    repeat (2) @(negedge clk);
    bus.r = 3'b111;
    @(negedge clk);
    check_idle("reset_hold");

    // Reset release with all requesting: requester 0 first.
    step(3'b111, 1'b1);
    // Single requester held, then dropped.
    run(3'b010, 20);
    run(3'b000, 2);
    // Full contention including wrap.
    run(3'b111, 30);
    run(3'b000, 2);
    // Voluntary handoff, then a full tenure for the new owner.
    run(3'b001, 1);
    run(3'b011, 2);
    run(3'b010, 1);
    run(3'b111, 12);
    run(3'b000, 2);
    // Rotation past a lower-indexed waiter.
    run(3'b010, 2);
    run(3'b101, 1);
    run(3'b001, 3);
    run(3'b000, 2);
    // Saturated hold then a late competitor.
    run(3'b100, 12);
    run(3'b110, 3);

    // Asynchronous reset mid-grant.
    run(3'b100, 3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_idle("reset_async");
    model_reset();
    repeat (2) @(posedge clk);
    step(3'b111, 1'b1);
    run(3'b111, 3);

    // Randomized request patterns held for random durations.
    for (int k = 0; k < 60; k++) begin
      logic [2:0] rv;
      int n;
      rv = 3'($urandom_range(0, 7));
      n  = $urandom_range(1, 14);
      run(rv, n);
    end

    @(posedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions, want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
